// File: rtl/mult8_seq.sv
// ----------------------------------------------------------------------------
// mult8_seq
//   Sequential unsigned 8x8 -> 16-bit multiplier. One combinational 4x4 array
//   multiplier is reused across four cycles. Each cycle handles one nibble
//   partial product and adds it, shifted, into a 16-bit accumulator.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request; accepted when ready is high
//   a, b      8-bit operands; captured only on an accepting edge
//   ready     high in IDLE or DONE (a start will be accepted)
//   busy      high while the four partial products are accumulated
//   done      one-cycle pulse; p is final
//   p         16-bit product; holds until the next accepted start
//   op_count  completed multiplies, wraps 0xFF -> 0x00
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// multiplier
//   Combinational 4x4 unsigned array multiplier. Each row is a ANDed with one
//   bit of b and shifted to that bit's weight. The rows are then summed.
//
// Ports
//   a, b   4-bit operands
//   p      8-bit product
// ----------------------------------------------------------------------------
module multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    always_comb begin
        // NOTE: combinational logic uses blocking '=' so that each row sees
        // the running sum. The default assignment first prevents a latch.
        p = 8'h00;
        for (int i = 0; i < 4; i++) begin
            p = p + (8'({4'b0000, a & {4{b[i]}}}) << i);
        end
    end

endmodule

module mult8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] p,
    output logic [7:0]  op_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PP0  = 3'd1,
        S_PP1  = 3'd2,
        S_PP2  = 3'd3,
        S_PP3  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;

    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  pp;
    logic [15:0] addend;

    // Select the operand nibbles for the current partial product.
    // PP1 and PP3 use the high nibble of a_q.
    // PP2 and PP3 use the high nibble of b_q.
    always_comb begin
        mul_a = a_q[3:0];
        mul_b = b_q[3:0];
        if (state == S_PP1 || state == S_PP3) mul_a = a_q[7:4];
        if (state == S_PP2 || state == S_PP3) mul_b = b_q[7:4];
    end

    multiplier u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    // Weight of the partial product. pp is zero-extended before it is shifted.
    always_comb begin
        addend = {8'h00, pp};
        case (state)
            S_PP1, S_PP2: addend = {8'h00, pp} << 4;
            S_PP3:        addend = {8'h00, pp} << 8;
            default:      addend = {8'h00, pp};
        endcase
    end

    assign p = acc;

    // The FSM, datapath registers and decoded outputs sit in one block.
    // ready/busy/done are registered together with the next state, so they
    // always match that state's decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand registers are reset along with the control
            // state, so a_q/b_q read as zero after reset instead of holding
            // stale operands.
            state    <= S_IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            acc      <= 16'h0000;
            op_count <= 8'h00;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so that every
            // register samples values from before the edge.
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc   <= 16'h0000;
                        state <= S_PP0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                S_PP0: begin
                    acc   <= acc + addend;
                    state <= S_PP1;
                end
                S_PP1: begin
                    acc   <= acc + addend;
                    state <= S_PP2;
                end
                S_PP2: begin
                    acc   <= acc + addend;
                    state <= S_PP3;
                end
                S_PP3: begin
                    acc      <= acc + addend;
                    state    <= S_DONE;
                    op_count <= op_count + 8'h01;
                    ready    <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult8_seq.sv
// ----------------------------------------------------------------------------
// tb_mult8_seq
//   Directed and random stimulus for mult8_seq. The reference model is plain
//   integer multiplication plus a completion counter.
// ----------------------------------------------------------------------------
module tb_mult8_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] p;
    logic [7:0]  op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    mult8_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .p        (p),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the stimulus below is a fixed number of cycles.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one multiply. The caller must be at a sample point with ready=1.
    // keep_start holds start high so that the DONE cycle accepts the next op.
    // poke raises start with junk operands so that it is sampled at E2.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input bit keep_start, input bit poke,
                          input string tag);
        logic [15:0] exp_p;
        exp_p = 16'(int'(x) * int'(y));
        check({tag, " ready before accept"}, ready, 1);
        a = x;
        b = y;
        start = 1'b1;
        step();                                   // E0: accept
        for (int k = 0; k < 4; k++) begin
            check({tag, " busy"}, busy, 1);
            check({tag, " done early"}, done, 0);
            check({tag, " ready while busy"}, ready, 0);
            // Operands may change freely while the operation is busy.
            a = 8'($urandom);
            b = 8'($urandom);
            start = keep_start || (poke && k == 1);
            step();                               // E(k+1)
        end
        exp_cnt++;
        check({tag, " done"}, done, 1);
        check({tag, " product"}, p, exp_p);
        check({tag, " op_count"}, op_count, 32'(exp_cnt[7:0]));
        check({tag, " busy at done"}, busy, 0);
        check({tag, " ready at done"}, ready, 1);
    endtask

    // After a single operation with start released, done must drop and p hold.
    task automatic after_single(input logic [15:0] exp_p, input string tag);
        start = 1'b0;
        step();
        check({tag, " done once"}, done, 0);
        check({tag, " p holds"}, p, exp_p);
        check({tag, " idle ready"}, ready, 1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        #12;
        check("reset p", p, 16'h0000);
        check("reset op_count", op_count, 8'h00);
        check("reset ready", ready, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Directed single operations.
        run_op(8'h12, 8'h34, 1'b0, 1'b0, "op12x34");
        check("op12x34 literal", p, 16'h03A8);
        after_single(16'h03A8, "op12x34");
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0, "opFFxFF");
        check("opFFxFF literal", p, 16'hFE01);
        after_single(16'hFE01, "opFFxFF");
        run_op(8'h00, 8'hFF, 1'b0, 1'b0, "op00xFF");
        after_single(16'h0000, "op00xFF");
        run_op(8'hA5, 8'h5A, 1'b0, 1'b0, "opA5x5A");
        check("opA5x5A literal", p, 16'h3A02);
        after_single(16'h3A02, "opA5x5A");

        // Back-to-back with start held: done lands at E4, E9, E14.
        run_op(8'h03, 8'h05, 1'b1, 1'b0, "b2b0");
        run_op(8'h10, 8'h10, 1'b1, 1'b0, "b2b1");
        run_op(8'h80, 8'h02, 1'b0, 1'b0, "b2b2");
        after_single(16'h0100, "b2b2");

        // A start pulse during the busy phase must be ignored.
        run_op(8'h37, 8'hC9, 1'b0, 1'b1, "ignored");
        after_single(16'(int'(8'h37) * int'(8'hC9)), "ignored");
        check("ignored no second busy", busy, 0);

        // Asynchronous reset between E2 and E3.
        a = 8'h9C;
        b = 8'h71;
        start = 1'b1;
        step();                                   // E0
        start = 1'b0;
        step();                                   // E1
        step();                                   // E2
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        check("async rst p", p, 16'h0000);
        check("async rst busy", busy, 0);
        check("async rst ready", ready, 1);
        check("async rst op_count", op_count, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("post rst no done", done, 0);
        end
        run_op(8'h9C, 8'h71, 1'b0, 1'b0, "fresh");
        after_single(16'(int'(8'h9C) * int'(8'h71)), "fresh");

        // Random single operations.
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 1'b0, 1'b0, "rand");
            after_single(16'(int'(ra) * int'(rb)), "rand");
        end

        // 256 back-to-back multiplies from a fresh reset: op_count wraps.
        @(negedge clk);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        exp_cnt = 0;
        step();
        for (int i = 0; i < 256; i++) begin
            run_op(8'($urandom), 8'($urandom), i != 255, 1'b0, "wrap");
            if (i == 254) check("wrap count 255", op_count, 8'hFF);
            if (i == 255) check("wrap count 256", op_count, 8'h00);
        end
        start = 1'b0;
        step();
        check("wrap final done low", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
